// File: rtl/det_pkg.sv
// Shared types and constants for the determinant batch scheduler.
// Imported by the scheduler top and its timeout counter.
package det_pkg;

    localparam int ADDR_W     = 4;
    localparam int ROM_DATA_W = 8;
    localparam int DET_W      = 2 * ROM_DATA_W;

    localparam logic [ADDR_W-1:0] MAX_BASE = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

endpackage

// File: rtl/det_timeout_counter.sv
// Cycle counter guarding a single determinant job.
// o_expired marks the TIMEOUT-th enabled cycle after a clear.
module det_timeout_counter
    import det_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/det_batch_scheduler.sv
// Walks a batch of 3x3 matrices through the determinant unit,
// returning one result per job over a valid/ready handshake.
module det_batch_scheduler
    import det_pkg::*;
#(
    parameter int STRIDE  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              batch_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [2:0]        job_count,
    input  logic              abort,
    output logic              det_start,
    output logic [ADDR_W-1:0] det_start_adress,
    output logic              det_reset,
    input  logic              det_done,
    input  logic [DET_W-1:0]  det_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DET_W-1:0]  res_data,
    output logic [2:0]        res_index,
    output logic [1:0]        res_err,
    output logic              busy,
    output logic              batch_done
);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [2:0]         r_remaining;
    logic [2:0]         r_index;
    logic [DET_W-1:0]   r_res_data;
    err_t               r_res_err;
    logic               r_det_reset;

    logic w_active;
    logic w_abort;
    logic w_expired;
    logic w_timeout;
    logic w_xfer;
    logic w_range_err;
    logic w_in_job;

    assign w_active    = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign w_abort     = abort && w_active;
    assign w_in_job    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_range_err = r_cur_addr > MAX_BASE;
    assign w_timeout   = (r_state == S_WAIT) && w_expired
                         && !det_done && !abort;
    assign w_xfer      = (r_state == S_HOLD) && res_ready && !abort;

    det_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_clear  (r_state == S_ISSUE),
        .i_enable (r_state == S_WAIT),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (batch_start) w_next = S_CHECK;
            S_CHECK:  w_next = w_range_err ? S_HOLD : S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT:   if (det_done || w_timeout) w_next = S_HOLD;
            S_HOLD: begin
                if (res_ready) begin
                    w_next = (r_remaining == 3'd0) ? S_FINISH : S_CHECK;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // Abort wins over any handshake or completion in the same cycle
        if (w_abort) w_next = S_FINISH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_index     <= '0;
            r_res_data  <= '0;
            r_res_err   <= ERR_OK;
            r_det_reset <= 1'b1;
        end else begin
            r_det_reset <= w_abort && w_in_job;
            if ((r_state == S_IDLE) && batch_start) begin
                r_cur_addr  <= base_addr;
                r_remaining <= job_count;
                r_index     <= '0;
            end
            if ((r_state == S_CHECK) && w_range_err) begin
                r_res_data <= '0;
                r_res_err  <= ERR_RANGE;
            end
            if ((r_state == S_WAIT) && det_done) begin
                r_res_data <= det_result;
                r_res_err  <= ERR_OK;
            end else if (w_timeout) begin
                r_res_data <= '0;
                r_res_err  <= ERR_TIMEOUT;
            end
            if (w_xfer && (r_remaining != 3'd0)) begin
                r_remaining <= r_remaining - 1'b1;
                r_index     <= r_index + 1'b1;
                r_cur_addr  <= r_cur_addr + ADDR_W'(STRIDE);
            end
        end
    end

    // Timeout reset is driven in the expiry cycle itself
    assign det_reset        = r_det_reset | w_timeout;
    assign det_start        = (r_state == S_ISSUE);
    assign det_start_adress = w_in_job ? r_cur_addr : '0;
    assign res_valid        = (r_state == S_HOLD);
    assign res_data         = res_valid ? r_res_data : '0;
    assign res_index        = res_valid ? r_index : '0;
    assign res_err          = res_valid ? r_res_err : ERR_OK;
    assign busy             = (r_state != S_IDLE);
    assign batch_done       = (r_state == S_FINISH);

endmodule

// File: tb/tb_det_batch_scheduler.sv
// Bench for det_batch_scheduler: mock determinant unit,
// event logs and a job-list model of each batch.
module tb_det_batch_scheduler;

    localparam int STRIDE  = 1;
    localparam int TIMEOUT = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        batch_start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [2:0]  job_count = '0;
    logic        abort = 1'b0;
    logic        det_done = 1'b0;
    logic [15:0] det_result = '0;
    logic        res_ready = 1'b0;
    logic        det_start;
    logic [3:0]  det_start_adress;
    logic        det_reset;
    logic        res_valid;
    logic [15:0] res_data;
    logic [2:0]  res_index;
    logic [1:0]  res_err;
    logic        busy;
    logic        batch_done;

    det_batch_scheduler #(
        .STRIDE (STRIDE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .batch_start     (batch_start),
        .base_addr       (base_addr),
        .job_count       (job_count),
        .abort           (abort),
        .det_start       (det_start),
        .det_start_adress(det_start_adress),
        .det_reset       (det_reset),
        .det_done        (det_done),
        .det_result      (det_result),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_index       (res_index),
        .res_err         (res_err),
        .busy            (busy),
        .batch_done      (batch_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
    } start_ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [2:0]  idx;
        logic [1:0]  err;
    } xfer_ev_t;

    typedef struct {
        int         job;
        logic [3:0] addr;
    } exp_start_t;

    start_ev_t  start_q[$];
    xfer_ev_t   xfer_q[$];
    int         rst_q[$];
    int         done_q[$];
    exp_start_t exp_s[$];
    xfer_ev_t   exp_x[$];

    int n_cmp = 0;
    int n_bad = 0;
    int clr_gen = 0;
    int seen_gen = 0;
    bit rand_ready = 1'b0;

    int          mock_lat = 0;
    bit          mock_fixed = 1'b0;
    logic [15:0] mock_fix_val = '0;
    logic [15:0] mock_salt = '0;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    logic [3:0]  m_addr = '0;

    function automatic logic [15:0] mock_val(input logic [3:0] a);
        if (mock_fixed) return mock_fix_val;
        return mock_salt ^ (16'(a) * 16'h0101);
    endfunction

    // Event logger, sampled mid-cycle
    always @(negedge clock) begin
        if (clr_gen != seen_gen) begin
            start_q.delete();
            xfer_q.delete();
            rst_q.delete();
            done_q.delete();
            seen_gen <= clr_gen;
        end else begin
            if (det_start) start_q.push_back('{cyc, det_start_adress});
            if (det_reset) rst_q.push_back(cyc);
            if (res_valid && res_ready && !abort && !reset)
                xfer_q.push_back('{cyc, res_data, res_index, res_err});
            if (batch_done) done_q.push_back(cyc);
        end
    end

    // Mock determinant unit: done mock_lat cycles after det_start
    always @(negedge clock) begin
        det_done <= 1'b0;
        if (reset || det_reset) begin
            m_pend <= 1'b0;
        end else if (det_start) begin
            m_pend <= (mock_lat != 0);
            m_cnt  <= mock_lat;
            m_addr <= det_start_adress;
        end else if (m_pend) begin
            if (m_cnt == 1) begin
                det_done   <= 1'b1;
                det_result <= mock_val(m_addr);
                m_pend     <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_logs();
        clr_gen = clr_gen + 1;
        tick();
    endtask

    task automatic start_batch(input logic [3:0] b, input logic [2:0] jc,
                               output int bs);
        batch_start = 1'b1;
        base_addr   = b;
        job_count   = jc;
        bs          = cyc;
        tick();
        batch_start = 1'b0;
        base_addr   = 4'($urandom);
        job_count   = 3'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected job list from base, count and stride alone
    task automatic build_model(input logic [3:0] b, input logic [2:0] jc);
        exp_s.delete();
        exp_x.delete();
        for (int j = 0; j <= int'(jc); j++) begin
            logic [3:0] a;
            a = 4'((int'(b) + j * STRIDE) % 16);
            if (a > 4'd7) begin
                exp_x.push_back('{0, 16'h0, 3'(j), 2'b01});
            end else begin
                exp_s.push_back('{j, a});
                exp_x.push_back('{0, mock_val(a), 3'(j), 2'b00});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        batch_start = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (det_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL reset.det_reset got %b want 1", det_reset);
        end
        n_cmp++;
        if ({det_start, det_start_adress, res_valid, res_data, res_index,
             res_err, busy, batch_done} !== '0) begin
            n_bad++;
            $display("FAIL reset.outputs got %b/%h/%b/%h/%h/%h/%b/%b want all 0",
                     det_start, det_start_adress, res_valid, res_data,
                     res_index, res_err, busy, batch_done);
        end
        reset = 1'b0;
        batch_start = 1'b0;
        tick();
        n_cmp++;
        if ({det_reset, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset.release got det_reset=%b busy=%b want 0 0",
                     det_reset, busy);
        end
    endtask

    task automatic test_single_job();
        int bs;
        bit ok;
        clear_logs();
        mock_fixed = 1'b1;
        mock_fix_val = 16'h0012;
        mock_lat = 40;
        res_ready = 1'b1;
        start_batch(4'd1, 3'd0, bs);
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single.done got none want batch_done");
        end
        n_cmp++;
        if (start_q.size() !== 1) begin
            n_bad++;
            $display("FAIL single.nstart got %0d want 1", start_q.size());
        end else begin
            n_cmp++;
            if (start_q[0].cyc !== bs + 2 || start_q[0].addr !== 4'd1) begin
                n_bad++;
                $display("FAIL single.start got cyc %0d addr %0d want %0d 1",
                         start_q[0].cyc, start_q[0].addr, bs + 2);
            end
        end
        n_cmp++;
        if (xfer_q.size() !== 1) begin
            n_bad++;
            $display("FAIL single.nxfer got %0d want 1", xfer_q.size());
        end else begin
            n_cmp++;
            if ({xfer_q[0].data, xfer_q[0].idx, xfer_q[0].err}
                    !== {16'h0012, 3'd0, 2'd0}) begin
                n_bad++;
                $display("FAIL single.result got %h/%0d/%0d want 0012/0/0",
                         xfer_q[0].data, xfer_q[0].idx, xfer_q[0].err);
            end
            n_cmp++;
            if (xfer_q[0].cyc !== bs + 2 + 41) begin
                n_bad++;
                $display("FAIL single.latency got %0d want %0d",
                         xfer_q[0].cyc, bs + 43);
            end
            n_cmp++;
            if (done_q.size() !== 1 || done_q[0] !== xfer_q[0].cyc + 1) begin
                n_bad++;
                $display("FAIL single.batch_done got n=%0d want one at %0d",
                         done_q.size(), xfer_q[0].cyc + 1);
            end
        end
        n_cmp++;
        if (rst_q.size() !== 0) begin
            n_bad++;
            $display("FAIL single.det_reset got %0d pulses want 0", rst_q.size());
        end
        mock_fixed = 1'b0;
    endtask

    task automatic test_stride_range(input logic [3:0] b, input int nstart);
        int bs;
        bit ok;
        clear_logs();
        mock_salt = 16'($urandom);
        mock_lat = $urandom_range(1, 10);
        res_ready = 1'b1;
        start_batch(b, 3'd2, bs);
        wait_done(300, ok);
        n_cmp++;
        if (!ok || start_q.size() !== nstart || xfer_q.size() !== 3) begin
            n_bad++;
            $display("FAIL batch%0d.counts got done=%b starts=%0d xfers=%0d want 1 %0d 3",
                     b, ok, start_q.size(), xfer_q.size(), nstart);
        end
        for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            logic [15:0] ed;
            logic [1:0] ee;
            a = b + 4'(k);
            ed = (a > 4'd7) ? 16'h0 : mock_val(a);
            ee = (a > 4'd7) ? 2'b01 : 2'b00;
            if (k < start_q.size()) begin
                n_cmp++;
                if (start_q[k].addr !== a) begin
                    n_bad++;
                    $display("FAIL batch%0d.addr%0d got %0d want %0d",
                             b, k, start_q[k].addr, a);
                end
            end
            if (k < xfer_q.size()) begin
                n_cmp++;
                if ({xfer_q[k].data, xfer_q[k].idx, xfer_q[k].err}
                        !== {ed, 3'(k), ee}) begin
                    n_bad++;
                    $display("FAIL batch%0d.res%0d got %h/%0d/%0d want %h/%0d/%0d",
                             b, k, xfer_q[k].data, xfer_q[k].idx,
                             xfer_q[k].err, ed, k, ee);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int bs;
        bit ok;
        clear_logs();
        mock_lat = 0;
        res_ready = 1'b1;
        start_batch(4'd2, 3'd1, bs);
        wait_done(700, ok);
        n_cmp++;
        if (!ok || start_q.size() !== 2 || rst_q.size() !== 2
                || xfer_q.size() !== 2) begin
            n_bad++;
            $display("FAIL tmo.counts got done=%b starts=%0d resets=%0d xfers=%0d want 1 2 2 2",
                     ok, start_q.size(), rst_q.size(), xfer_q.size());
        end
        for (int k = 0; k < 2; k++) begin
            if (k < start_q.size() && k < rst_q.size() && k < xfer_q.size()) begin
                n_cmp++;
                if (rst_q[k] !== start_q[k].cyc + TIMEOUT
                        || start_q[k].addr !== 4'(2 + k)) begin
                    n_bad++;
                    $display("FAIL tmo.reset%0d got %0d addr %0d want %0d addr %0d",
                             k, rst_q[k], start_q[k].addr,
                             start_q[k].cyc + TIMEOUT, 2 + k);
                end
                n_cmp++;
                if ({xfer_q[k].data, xfer_q[k].idx, xfer_q[k].err}
                        !== {16'h0, 3'(k), 2'b10}
                        || xfer_q[k].cyc !== rst_q[k] + 1) begin
                    n_bad++;
                    $display("FAIL tmo.res%0d got %h/%0d/%0d at %0d want 0/%0d/2 at %0d",
                             k, xfer_q[k].data, xfer_q[k].idx, xfer_q[k].err,
                             xfer_q[k].cyc, k, rst_q[k] + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bs;
        bit ok;
        logic [15:0] ed;
        clear_logs();
        mock_salt = 16'($urandom);
        mock_lat = 4;
        res_ready = 1'b0;
        ed = mock_val(4'd3);
        start_batch(4'd3, 3'd1, bs);
        wait_valid(50, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp.valid got none want res_valid");
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            n_cmp++;
            if ({res_valid, res_data, res_index, res_err}
                    !== {1'b1, ed, 3'd0, 2'd0} || start_q.size() !== 1) begin
                n_bad++;
                $display("FAIL bp.hold%0d got %b/%h/%0d/%0d starts=%0d want 1/%h/0/0 starts=1",
                         i, res_valid, res_data, res_index, res_err,
                         start_q.size(), ed);
            end
        end
        res_ready = 1'b1;
        wait_done(100, ok);
        n_cmp++;
        if (!ok || start_q.size() !== 2 || xfer_q.size() !== 2) begin
            n_bad++;
            $display("FAIL bp.counts got done=%b starts=%0d xfers=%0d want 1 2 2",
                     ok, start_q.size(), xfer_q.size());
        end else begin
            n_cmp++;
            if (start_q[1].cyc <= xfer_q[0].cyc || start_q[1].addr !== 4'd4
                    || xfer_q[1].data !== mock_val(4'd4)) begin
                n_bad++;
                $display("FAIL bp.second got start %0d addr %0d data %h want after %0d addr 4 data %h",
                         start_q[1].cyc, start_q[1].addr, xfer_q[1].data,
                         xfer_q[0].cyc, mock_val(4'd4));
            end
        end
    endtask

    task automatic test_abort();
        int bs;
        int a;
        bit ok;
        clear_logs();
        mock_lat = 0;
        res_ready = 1'b1;
        start_batch(4'd0, 3'd3, bs);
        wait_starts(1, 20, ok);
        repeat (5) tick();
        abort = 1'b1;
        a = cyc;
        tick();
        abort = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (!ok || rst_q.size() !== 1 || done_q.size() !== 1
                || xfer_q.size() !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_wait.counts got start=%b resets=%0d dones=%0d xfers=%0d busy=%b want 1 1 1 0 0",
                     ok, rst_q.size(), done_q.size(), xfer_q.size(), busy);
        end else begin
            n_cmp++;
            if (rst_q[0] !== a + 1 || done_q[0] !== a + 1) begin
                n_bad++;
                $display("FAIL abort_wait.timing got reset %0d done %0d want %0d %0d",
                         rst_q[0], done_q[0], a + 1, a + 1);
            end
        end
        clear_logs();
        mock_lat = 3;
        res_ready = 1'b0;
        start_batch(4'd0, 3'd2, bs);
        wait_valid(30, ok);
        abort = 1'b1;
        res_ready = 1'b1;
        a = cyc;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (!ok || xfer_q.size() !== 0 || rst_q.size() !== 0
                || start_q.size() !== 1 || done_q.size() !== 1) begin
            n_bad++;
            $display("FAIL abort_hold.counts got valid=%b xfers=%0d resets=%0d starts=%0d dones=%0d want 1 0 0 1 1",
                     ok, xfer_q.size(), rst_q.size(), start_q.size(),
                     done_q.size());
        end else begin
            n_cmp++;
            if (done_q[0] !== a + 1) begin
                n_bad++;
                $display("FAIL abort_hold.done got %0d want %0d", done_q[0], a + 1);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int bs;
        bit ok;
        clear_logs();
        mock_lat = 0;
        res_ready = 1'b1;
        start_batch(4'd1, 3'd1, bs);
        wait_starts(1, 20, ok);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({det_start, det_start_adress, res_valid, res_data, res_index,
             res_err, busy, batch_done, det_reset} !== 31'd1) begin
            n_bad++;
            $display("FAIL rst_wait.outputs got busy=%b valid=%b start=%b det_reset=%b want 0 0 0 1",
                     busy, res_valid, det_start, det_reset);
        end
        reset = 1'b0;
        clear_logs();
        repeat (10) tick();
        n_cmp++;
        if (done_q.size() !== 0 || xfer_q.size() !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait.quiet got dones=%0d xfers=%0d busy=%b want 0 0 0",
                     done_q.size(), xfer_q.size(), busy);
        end
        clear_logs();
        mock_salt = 16'($urandom);
        mock_lat = 6;
        start_batch(4'd4, 3'd0, bs);
        wait_done(100, ok);
        n_cmp++;
        if (!ok || start_q.size() !== 1 || xfer_q.size() !== 1) begin
            n_bad++;
            $display("FAIL rst_wait.restart got done=%b starts=%0d xfers=%0d want 1 1 1",
                     ok, start_q.size(), xfer_q.size());
        end else begin
            n_cmp++;
            if (start_q[0].cyc !== bs + 2 || start_q[0].addr !== 4'd4
                    || xfer_q[0].data !== mock_val(4'd4)
                    || xfer_q[0].err !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_wait.result got start %0d addr %0d data %h err %0d want %0d 4 %h 0",
                         start_q[0].cyc, start_q[0].addr, xfer_q[0].data,
                         xfer_q[0].err, bs + 2, mock_val(4'd4));
            end
        end
    endtask

    task automatic test_random();
        int bs;
        bit ok;
        logic [3:0] b;
        logic [2:0] jc;
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            mock_salt = 16'($urandom);
            mock_lat = $urandom_range(1, 20);
            b = 4'($urandom);
            jc = 3'($urandom);
            build_model(b, jc);
            rand_ready = 1'b1;
            start_batch(b, jc, bs);
            wait_done(3000, ok);
            rand_ready = 1'b0;
            res_ready = 1'b0;
            n_cmp++;
            if (!ok || start_q.size() !== exp_s.size()
                    || xfer_q.size() !== exp_x.size() || done_q.size() !== 1) begin
                n_bad++;
                $display("FAIL rand%0d.counts got done=%b starts=%0d xfers=%0d dones=%0d want 1 %0d %0d 1",
                         it, ok, start_q.size(), xfer_q.size(), done_q.size(),
                         exp_s.size(), exp_x.size());
            end
            for (int k = 0; k < exp_s.size() && k < start_q.size(); k++) begin
                n_cmp++;
                if (start_q[k].addr !== exp_s[k].addr) begin
                    n_bad++;
                    $display("FAIL rand%0d.addr%0d got %0d want %0d",
                             it, k, start_q[k].addr, exp_s[k].addr);
                end
                if (exp_s[k].job > 0 && exp_s[k].job <= xfer_q.size()) begin
                    n_cmp++;
                    if (start_q[k].cyc <= xfer_q[exp_s[k].job - 1].cyc) begin
                        n_bad++;
                        $display("FAIL rand%0d.order%0d got start %0d want after %0d",
                                 it, k, start_q[k].cyc,
                                 xfer_q[exp_s[k].job - 1].cyc);
                    end
                end
            end
            for (int k = 0; k < exp_x.size() && k < xfer_q.size(); k++) begin
                n_cmp++;
                if ({xfer_q[k].data, xfer_q[k].idx, xfer_q[k].err}
                        !== {exp_x[k].data, exp_x[k].idx, exp_x[k].err}) begin
                    n_bad++;
                    $display("FAIL rand%0d.res%0d got %h/%0d/%0d want %h/%0d/%0d",
                             it, k, xfer_q[k].data, xfer_q[k].idx,
                             xfer_q[k].err, exp_x[k].data, exp_x[k].idx,
                             exp_x[k].err);
                end
            end
            if (done_q.size() == 1 && xfer_q.size() > 0) begin
                n_cmp++;
                if (done_q[0] !== xfer_q[xfer_q.size() - 1].cyc + 1) begin
                    n_bad++;
                    $display("FAIL rand%0d.done got %0d want %0d", it,
                             done_q[0], xfer_q[xfer_q.size() - 1].cyc + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_stride_range(4'd0, 3);
        test_stride_range(4'd6, 2);
        test_timeout();
        test_backpressure();
        test_abort();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/det_batch_scheduler.md
DET_BATCH_SCHEDULER -- requirements
Module: det_batch_scheduler

Interface
REQ-001 Parameter STRIDE, default 1: address increment between consecutive matrices (1..9).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for det_done per job.
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 batch_start  input  1  one-cycle request to begin a batch; sampled only in IDLE.
REQ-006 base_addr  input  4  ROM start address of the first matrix.
REQ-007 job_count  input  3  number of matrices minus 1 (0 means 1 job, 7 means 8 jobs).
REQ-008 abort  input  1  terminate the batch at the next cycle.
REQ-009 det_start  output  1  one-cycle start pulse to the 3x3 determinant unit.
REQ-010 det_start_adress  output  4  start address presented to the determinant unit.
REQ-011 det_reset  output  1  one-cycle reset pulse to the determinant unit.
REQ-012 det_done  input  1  completion flag from the determinant unit.
REQ-013 det_result  input  16  determinant value, valid while det_done=1.
REQ-014 res_valid / res_ready  output/input  1/1  result handshake; transfer occurs when both are 1.
REQ-015 res_data  output  16  determinant result, or 0 on error.
REQ-016 res_index  output  3  job number 0..7 of res_data.
REQ-017 res_err  output  2  00 ok, 01 address out of range, 10 timeout.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 batch_done  output  1  one-cycle pulse after the last result transfers or an abort completes.

Function
REQ-020 FSM states: IDLE, CHECK, ISSUE, WAIT, HOLD, FINISH.
REQ-021 IDLE: batch_start=1 latches base_addr into cur_addr, job_count into remaining, clears the index, and goes to CHECK.
REQ-022 CHECK: cur_addr > 7 (matrix would exceed word 15) loads res_err=01, res_data=0, and goes to HOLD without det_start; otherwise goes to ISSUE.
REQ-023 ISSUE: det_start=1 and det_start_adress=cur_addr for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-024 det_start_adress is held stable from ISSUE until leaving WAIT.
REQ-025 WAIT: det_done=1 captures det_result into res_data with res_err=00 and goes to HOLD.
REQ-026 WAIT: if the counter reaches TIMEOUT with no det_done, pulse det_reset for 1 cycle, set res_data=0 and res_err=10, and go to HOLD.
REQ-027 HOLD: res_valid=1 with res_data, res_index, and res_err stable until res_ready=1.
REQ-028 On the HOLD transfer with remaining=0, go to FINISH.
REQ-029 On the HOLD transfer with remaining>0: decrement remaining, increment index, cur_addr=cur_addr+STRIDE modulo 16 (4-bit wrap), and go to CHECK.
REQ-030 No det_start is issued while a result is pending (backpressure).
REQ-031 FINISH: batch_done=1 for one cycle, then go to IDLE.
REQ-032 abort=1 in any non-IDLE state: pulse det_reset if in ISSUE or WAIT, drop res_valid, and go to FINISH.
REQ-033 abort takes priority over det_done, timeout, and res_ready arriving in the same cycle.
REQ-034 batch_start outside IDLE is ignored.
REQ-035 A simultaneous batch_start and abort in IDLE starts the batch.
REQ-036 det_done outside WAIT is ignored.
REQ-037 Minimum latency: batch_start to det_start is 2 cycles (IDLE to CHECK to ISSUE).
REQ-038 Minimum latency: det_done to res_valid is 1 cycle.

Reset
REQ-039 When reset=1 at a clock edge, the state goes to IDLE.
REQ-040 When reset=1 at a clock edge, every output is 0, except det_reset, which is 1 for that cycle.
REQ-041 When reset=1 at a clock edge, all counters clear; reset during a job discards the job without a result or batch_done.

Structure
REQ-042 Shared package det_pkg holds the state enum, the error-code enum, and the constants ADDR_W=4, ROM_DATA_W=8, DET_W=16, MAX_BASE=7.
REQ-043 The single natural sub-module is det_timeout_counter (clear, enable, expired at TIMEOUT).
REQ-044 The top-level integration instantiates this block, the existing 3x3 determinant unit, and the 16x8 ROM.

Verification
REQ-045 Single job: base_addr=1, job_count=0, mock det_done with 16'h0012 after 40 cycles, res_ready=1 -> det_start 2 cycles after batch_start with address 1; res_valid with data 0012, index 0, err 00; batch_done 1 cycle after the transfer.
REQ-046 Stride and batch: base_addr=0, job_count=2, STRIDE=1 -> det_start addresses 0,1,2 in order; indices 0,1,2; exactly 3 det_start pulses.
REQ-047 Range error: base_addr=6, job_count=2 -> jobs 6 and 7 issued; job index 2 (address 8) gives err 01, data 0, no det_start.
REQ-048 Timeout: det_done never asserted, TIMEOUT=255 -> det_reset pulse 255 cycles after det_start; err 10; batch continues to the next job.
REQ-049 Backpressure: res_ready held low for 30 cycles -> res_valid and res_data held stable, no further det_start until the transfer.
REQ-050 Abort and reset: abort in WAIT -> det_reset pulse, then batch_done; reset mid-WAIT -> all outputs 0 next cycle, no batch_done, next batch_start accepted normally.
